// File: rtl/mem_stage_pkg.sv
// Shared types and encodings for the dual-slot memory stage.
package mem_stage_pkg;
  localparam int DATA_W    = 32;
  localparam int NUM_SLOTS = 2;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2} state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_LO = 4'b0011;
  localparam logic [3:0] BE_HI = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] sdata;
    logic              rd_we;
    logic [4:0]        rd;
    logic              ld;
    logic              st;
    logic [2:0]        f3;
  } slot_t;
endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for stores, load extraction/extension, alignment check.
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        f3,
  input  logic [DATA_W-1:0] sdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ldata,
  output logic              misalign
);
  logic [DATA_W-1:0] rsh;
  logic [7:0]        b;
  logic [15:0]       h;

  always_comb begin
    rsh      = rdata >> {addr_lo, 3'b000};
    b        = rsh[7:0];
    h        = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    be       = BE_W;
    wdata    = sdata;
    ldata    = rdata;
    misalign = 1'b0;
    case (f3[1:0])
      SZ_B: begin
        be    = BE_B0 << addr_lo;
        wdata = {4{sdata[7:0]}};
        ldata = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      end
      SZ_H: begin
        be       = addr_lo[1] ? BE_HI : BE_LO;
        wdata    = {2{sdata[15:0]}};
        ldata    = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
        misalign = addr_lo[0];
      end
      default: misalign = (addr_lo != 2'b00);
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// Dual-slot MEM stage: one load/store per bundle over a req/gnt/rvalid port.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid0_i,
  input  logic              valid1_i,
  input  logic [XLEN-1:0]   alu0_i,
  input  logic [XLEN-1:0]   alu1_i,
  input  logic [XLEN-1:0]   sdata0_i,
  input  logic [XLEN-1:0]   sdata1_i,
  input  logic              rd_we0_i,
  input  logic              rd_we1_i,
  input  logic [4:0]        rd0_i,
  input  logic [4:0]        rd1_i,
  input  logic              ld0_i,
  input  logic              st0_i,
  input  logic              ld1_i,
  input  logic              st1_i,
  input  logic [2:0]        f3_0_i,
  input  logic [2:0]        f3_1_i,
  output logic              stall_o,
  output logic              wm0_o,
  output logic [4:0]        am0_o,
  output logic              wm1_o,
  output logic [4:0]        am1_o,
  output logic [XLEN-1:0]   bypass_lsu0_o,
  output logic [XLEN-1:0]   bypass_lsu1_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              wb_valid0_o,
  output logic              wb_valid1_o,
  output logic              wb_we0_o,
  output logic              wb_we1_o,
  output logic [4:0]        wb_rd0_o,
  output logic [4:0]        wb_rd1_o,
  output logic [XLEN-1:0]   wb_data0_o,
  output logic [XLEN-1:0]   wb_data1_o,
  output logic              misalign_o
);
  slot_t [NUM_SLOTS-1:0] in_s, mem_q;
  state_e state_q, state_d;

  logic [NUM_SLOTS-1:0]             is_mem, wm, wb_v_d, wb_we_d, wb_v_q, wb_we_q;
  logic [NUM_SLOTS-1:0][4:0]        wb_rd_q;
  logic [NUM_SLOTS-1:0][DATA_W-1:0] wb_data_d, wb_data_q;

  logic              sel, has_mem, req, done, retire, fault;
  logic [DATA_W-1:0] op_alu, op_sdata, al_wdata, al_ldata;
  logic              op_ld, op_st, mis;
  logic [2:0]        op_f3;
  logic [3:0]        al_be;

  assign in_s[0] = {valid0_i, alu0_i, sdata0_i, rd_we0_i, rd0_i, ld0_i, st0_i, f3_0_i};
  assign in_s[1] = {valid1_i, alu1_i, sdata1_i, rd_we1_i, rd1_i, ld1_i, st1_i, f3_1_i};

  // Slot 0 has priority; slot 1 is served only when slot 0 carries no mem op.
  assign sel      = ~is_mem[0];
  assign has_mem  = |is_mem;
  assign op_alu   = mem_q[sel].alu;
  assign op_sdata = mem_q[sel].sdata;
  assign op_ld    = mem_q[sel].ld;
  assign op_st    = mem_q[sel].st;
  assign op_f3    = mem_q[sel].f3;

  lsu_align u_align (
    .addr_lo  (op_alu[1:0]),
    .f3       (op_f3),
    .sdata    (op_sdata),
    .rdata    (dmem_rdata_i),
    .be       (al_be),
    .wdata    (al_wdata),
    .ldata    (al_ldata),
    .misalign (mis)
  );

  // The request goes out from IDLE already so a granted store retires in one cycle.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: if (has_mem) begin
        if (mis) done = 1'b1;
        else begin
          req = 1'b1;
          if (!dmem_gnt_i) state_d = ST_REQ;
          else if (op_st)  done    = 1'b1;
          else             state_d = ST_WAIT;
        end
      end
      ST_REQ: begin
        req = 1'b1;
        if (dmem_gnt_i) begin
          if (op_st) begin done = 1'b1; state_d = ST_IDLE; end
          else state_d = ST_WAIT;
        end
      end
      ST_WAIT: if (dmem_rvalid_i) begin done = 1'b1; state_d = ST_IDLE; end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fault      = (state_q == ST_IDLE) & has_mem & mis;
  assign misalign_o = fault;
  assign stall_o    = has_mem & ~done;
  assign retire     = (mem_q[0].valid | mem_q[1].valid) & ~stall_o;

  assign dmem_req_o   = req;
  assign dmem_we_o    = req & op_st;
  assign dmem_addr_o  = req ? {op_alu[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_be_o    = req ? al_be : 4'd0;
  assign dmem_wdata_o = req ? al_wdata : '0;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    logic here;
    assign here         = has_mem & (sel == 1'(i));
    assign is_mem[i]    = mem_q[i].valid & (mem_q[i].ld | mem_q[i].st);
    assign wm[i]        = mem_q[i].valid & mem_q[i].rd_we & (mem_q[i].rd != 5'd0) & ~mem_q[i].ld;
    assign wb_v_d[i]    = mem_q[i].valid;
    assign wb_we_d[i]   = mem_q[i].valid & mem_q[i].rd_we & ~(fault & here);
    assign wb_data_d[i] = (here & op_ld) ? al_ldata : mem_q[i].alu;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      mem_q     <= '0;
      wb_v_q    <= '0;
      wb_we_q   <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      assert (!(&is_mem));
      state_q <= state_d;
      if (!stall_o) mem_q <= in_s;
      wb_v_q  <= retire ? wb_v_d  : '0;
      wb_we_q <= retire ? wb_we_d : '0;
      if (retire) begin
        wb_rd_q   <= {mem_q[1].rd, mem_q[0].rd};
        wb_data_q <= wb_data_d;
      end
    end
  end

  assign wm0_o         = wm[0];
  assign wm1_o         = wm[1];
  assign am0_o         = mem_q[0].rd;
  assign am1_o         = mem_q[1].rd;
  assign bypass_lsu0_o = mem_q[0].alu;
  assign bypass_lsu1_o = mem_q[1].alu;
  assign wb_valid0_o   = wb_v_q[0];
  assign wb_valid1_o   = wb_v_q[1];
  assign wb_we0_o      = wb_we_q[0];
  assign wb_we1_o      = wb_we_q[1];
  assign wb_rd0_o      = wb_rd_q[0];
  assign wb_rd1_o      = wb_rd_q[1];
  assign wb_data0_o    = wb_data_q[0];
  assign wb_data1_o    = wb_data_q[1];
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, stores, loads, misalign, reset abort.
module tb_mem_stage;
  logic        clk_i = 1'b0, rst_i;
  logic        valid0_i, valid1_i, rd_we0_i, rd_we1_i, ld0_i, st0_i, ld1_i, st1_i;
  logic [31:0] alu0_i, alu1_i, sdata0_i, sdata1_i, dmem_rdata_i;
  logic [4:0]  rd0_i, rd1_i;
  logic [2:0]  f3_0_i, f3_1_i;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic        stall_o, wm0_o, wm1_o, dmem_req_o, dmem_we_o, misalign_o;
  logic [4:0]  am0_o, am1_o, wb_rd0_o, wb_rd1_o;
  logic [31:0] bypass_lsu0_o, bypass_lsu1_o, dmem_addr_o, dmem_wdata_o, wb_data0_o, wb_data1_o;
  logic [3:0]  dmem_be_o;
  logic        wb_valid0_o, wb_valid1_o, wb_we0_o, wb_we1_o;
  int errors = 0, checks = 0;

  always #5 clk_i = ~clk_i;

  mem_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .valid0_i(valid0_i), .valid1_i(valid1_i), .alu0_i(alu0_i), .alu1_i(alu1_i),
    .sdata0_i(sdata0_i), .sdata1_i(sdata1_i), .rd_we0_i(rd_we0_i), .rd_we1_i(rd_we1_i),
    .rd0_i(rd0_i), .rd1_i(rd1_i), .ld0_i(ld0_i), .st0_i(st0_i), .ld1_i(ld1_i), .st1_i(st1_i),
    .f3_0_i(f3_0_i), .f3_1_i(f3_1_i), .stall_o(stall_o),
    .wm0_o(wm0_o), .am0_o(am0_o), .wm1_o(wm1_o), .am1_o(am1_o),
    .bypass_lsu0_o(bypass_lsu0_o), .bypass_lsu1_o(bypass_lsu1_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid0_o(wb_valid0_o), .wb_valid1_o(wb_valid1_o), .wb_we0_o(wb_we0_o), .wb_we1_o(wb_we1_o),
    .wb_rd0_o(wb_rd0_o), .wb_rd1_o(wb_rd1_o), .wb_data0_o(wb_data0_o), .wb_data1_o(wb_data1_o),
    .misalign_o(misalign_o)
  );

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic clear_in();
    valid0_i = 0; valid1_i = 0; alu0_i = 0; alu1_i = 0; sdata0_i = 0; sdata1_i = 0;
    rd_we0_i = 0; rd_we1_i = 0; rd0_i = 0; rd1_i = 0; ld0_i = 0; st0_i = 0; ld1_i = 0; st1_i = 0;
    f3_0_i = 0; f3_1_i = 0;
  endtask

  task automatic test_reset();
    clear_in(); dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0; rst_i = 1;
    tick(); tick(); rst_i = 0;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0h exp=0", stall_o); end
    checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got=%0h exp=0", dmem_req_o); end
    checks++; if (dmem_be_o !== 4'h0) begin errors++; $display("FAIL rst_be got=%0h exp=0", dmem_be_o); end
    checks++; if ({wm0_o, wm1_o, am0_o, am1_o} !== 12'h0) begin errors++; $display("FAIL rst_wm_am got=%0h exp=0", {wm0_o, wm1_o, am0_o, am1_o}); end
    checks++; if (bypass_lsu0_o !== 32'h0) begin errors++; $display("FAIL rst_bypass0 got=%0h exp=0", bypass_lsu0_o); end
    checks++; if ({wb_valid0_o, wb_valid1_o, wb_we0_o, wb_we1_o} !== 4'h0) begin errors++; $display("FAIL rst_wb_ctl got=%0h exp=0", {wb_valid0_o, wb_valid1_o, wb_we0_o, wb_we1_o}); end
    checks++; if (wb_data0_o !== 32'h0) begin errors++; $display("FAIL rst_wb_data0 got=%0h exp=0", wb_data0_o); end
    checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL rst_misalign got=%0h exp=0", misalign_o); end
  endtask

  task automatic test_alu();
    clear_in();
    valid0_i = 1; valid1_i = 1; rd_we0_i = 1; rd_we1_i = 1; rd0_i = 5; rd1_i = 6; alu0_i = 32'h11; alu1_i = 32'h22;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL alu_stall_in got=%0h exp=0", stall_o); end
    tick(); clear_in();
    checks++; if (wm0_o !== 1'b1) begin errors++; $display("FAIL alu_wm0 got=%0h exp=1", wm0_o); end
    checks++; if (am0_o !== 5'd5) begin errors++; $display("FAIL alu_am0 got=%0d exp=5", am0_o); end
    checks++; if (bypass_lsu0_o !== 32'h11) begin errors++; $display("FAIL alu_bypass0 got=%0h exp=11", bypass_lsu0_o); end
    checks++; if ({wm1_o, am1_o} !== {1'b1, 5'd6}) begin errors++; $display("FAIL alu_wm1_am1 got=%0h exp=26", {wm1_o, am1_o}); end
    checks++; if (bypass_lsu1_o !== 32'h22) begin errors++; $display("FAIL alu_bypass1 got=%0h exp=22", bypass_lsu1_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL alu_stall got=%0h exp=0", stall_o); end
    checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL alu_req got=%0h exp=0", dmem_req_o); end
    checks++; if (wb_valid0_o !== 1'b0) begin errors++; $display("FAIL alu_wb_early got=%0h exp=0", wb_valid0_o); end
    tick();
    checks++; if ({wb_valid0_o, wb_valid1_o, wb_we0_o, wb_we1_o} !== 4'hF) begin errors++; $display("FAIL alu_wb_ctl got=%0h exp=f", {wb_valid0_o, wb_valid1_o, wb_we0_o, wb_we1_o}); end
    checks++; if ({wb_rd0_o, wb_rd1_o} !== {5'd5, 5'd6}) begin errors++; $display("FAIL alu_wb_rd got=%0h exp=a6", {wb_rd0_o, wb_rd1_o}); end
    checks++; if (wb_data0_o !== 32'h11) begin errors++; $display("FAIL alu_wb_data0 got=%0h exp=11", wb_data0_o); end
    checks++; if (wb_data1_o !== 32'h22) begin errors++; $display("FAIL alu_wb_data1 got=%0h exp=22", wb_data1_o); end
    tick();
    checks++; if ({wb_valid0_o, wb_valid1_o} !== 2'b00) begin errors++; $display("FAIL alu_wb_drop got=%0h exp=0", {wb_valid0_o, wb_valid1_o}); end
  endtask

  task automatic test_store_sb();
    clear_in();
    valid1_i = 1; st1_i = 1; f3_1_i = 3'b000; alu1_i = 32'h1003; sdata1_i = 32'hA5;
    tick(); clear_in();
    for (int c = 0; c < 3; c++) begin
      checks++; if (dmem_req_o !== 1'b1) begin errors++; $display("FAIL sb_req c%0d got=%0h exp=1", c, dmem_req_o); end
      checks++; if ({dmem_we_o, dmem_be_o} !== 5'b1_1000) begin errors++; $display("FAIL sb_we_be c%0d got=%0h exp=18", c, {dmem_we_o, dmem_be_o}); end
      checks++; if (dmem_addr_o !== 32'h1000) begin errors++; $display("FAIL sb_addr c%0d got=%0h exp=1000", c, dmem_addr_o); end
      checks++; if (dmem_wdata_o !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata c%0d got=%0h exp=a5a5a5a5", c, dmem_wdata_o); end
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL sb_stall c%0d got=%0h exp=1", c, stall_o); end
      tick();
    end
    dmem_gnt_i = 1; #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL sb_stall_gnt got=%0h exp=0", stall_o); end
    checks++; if (dmem_be_o !== 4'b1000) begin errors++; $display("FAIL sb_be_gnt got=%0h exp=8", dmem_be_o); end
    tick(); dmem_gnt_i = 0;
    checks++; if ({wb_valid0_o, wb_valid1_o, wb_we1_o} !== 3'b010) begin errors++; $display("FAIL sb_wb got=%0h exp=2", {wb_valid0_o, wb_valid1_o, wb_we1_o}); end
    checks++; if ({dmem_req_o, stall_o} !== 2'b00) begin errors++; $display("FAIL sb_idle got=%0h exp=0", {dmem_req_o, stall_o}); end
  endtask

  task automatic test_store_sh();
    clear_in();
    valid0_i = 1; st0_i = 1; f3_0_i = 3'b001; alu0_i = 32'h6002; sdata0_i = 32'h1234ABCD;
    tick(); clear_in(); dmem_gnt_i = 1; #1;
    checks++; if (dmem_be_o !== 4'b1100) begin errors++; $display("FAIL sh_be got=%0h exp=c", dmem_be_o); end
    checks++; if (dmem_wdata_o !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata got=%0h exp=abcdabcd", dmem_wdata_o); end
    checks++; if (dmem_addr_o !== 32'h6000) begin errors++; $display("FAIL sh_addr got=%0h exp=6000", dmem_addr_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL sh_stall got=%0h exp=0", stall_o); end
    tick(); dmem_gnt_i = 0;
    checks++; if (wb_valid0_o !== 1'b1) begin errors++; $display("FAIL sh_wb got=%0h exp=1", wb_valid0_o); end
  endtask

  task automatic test_load_lh();
    clear_in();
    valid0_i = 1; ld0_i = 1; f3_0_i = 3'b001; alu0_i = 32'h2002; rd_we0_i = 1; rd0_i = 7;
    tick(); clear_in();
    checks++; if ({dmem_req_o, dmem_we_o, stall_o, wm0_o} !== 4'b1010) begin errors++; $display("FAIL lh_req got=%0h exp=a", {dmem_req_o, dmem_we_o, stall_o, wm0_o}); end
    checks++; if (dmem_addr_o !== 32'h2000) begin errors++; $display("FAIL lh_addr got=%0h exp=2000", dmem_addr_o); end
    dmem_gnt_i = 1; #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL lh_stall_gnt got=%0h exp=1", stall_o); end
    tick(); dmem_gnt_i = 0;
    for (int c = 0; c < 2; c++) begin
      checks++; if ({dmem_req_o, stall_o, wm0_o} !== 3'b010) begin errors++; $display("FAIL lh_wait c%0d got=%0h exp=2", c, {dmem_req_o, stall_o, wm0_o}); end
      tick();
    end
    dmem_rvalid_i = 1; dmem_rdata_i = 32'h80011234; #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lh_stall_rv got=%0h exp=0", stall_o); end
    tick(); dmem_rvalid_i = 0;
    checks++; if ({wb_valid0_o, wb_we0_o, wb_rd0_o} !== {2'b11, 5'd7}) begin errors++; $display("FAIL lh_wb_ctl got=%0h exp=67", {wb_valid0_o, wb_we0_o, wb_rd0_o}); end
    checks++; if (wb_data0_o !== 32'hFFFF8001) begin errors++; $display("FAIL lh_wb_data got=%0h exp=ffff8001", wb_data0_o); end
  endtask

  task automatic test_misalign();
    clear_in();
    valid0_i = 1; ld0_i = 1; f3_0_i = 3'b010; alu0_i = 32'h3001; rd_we0_i = 1; rd0_i = 8;
    valid1_i = 1; rd_we1_i = 1; rd1_i = 9; alu1_i = 32'h55;
    tick(); clear_in();
    checks++; if ({misalign_o, dmem_req_o, stall_o} !== 3'b100) begin errors++; $display("FAIL mis_pulse got=%0h exp=4", {misalign_o, dmem_req_o, stall_o}); end
    tick();
    checks++; if ({misalign_o, dmem_req_o} !== 2'b00) begin errors++; $display("FAIL mis_clear got=%0h exp=0", {misalign_o, dmem_req_o}); end
    checks++; if ({wb_valid0_o, wb_we0_o, wb_valid1_o, wb_we1_o} !== 4'b1011) begin errors++; $display("FAIL mis_wb_ctl got=%0h exp=b", {wb_valid0_o, wb_we0_o, wb_valid1_o, wb_we1_o}); end
    checks++; if (wb_data1_o !== 32'h55) begin errors++; $display("FAIL mis_wb_data1 got=%0h exp=55", wb_data1_o); end
  endtask

  task automatic test_reset_wait();
    clear_in();
    valid0_i = 1; ld0_i = 1; f3_0_i = 3'b010; alu0_i = 32'h5000; rd_we0_i = 1; rd0_i = 4;
    tick(); clear_in(); dmem_gnt_i = 1;
    tick(); dmem_gnt_i = 0;
    checks++; if ({dmem_req_o, stall_o} !== 2'b01) begin errors++; $display("FAIL rw_wait got=%0h exp=1", {dmem_req_o, stall_o}); end
    rst_i = 1; tick(); rst_i = 0;
    checks++; if ({stall_o, dmem_req_o, wm0_o, am0_o} !== 8'h0) begin errors++; $display("FAIL rw_outs got=%0h exp=0", {stall_o, dmem_req_o, wm0_o, am0_o}); end
    checks++; if (bypass_lsu0_o !== 32'h0) begin errors++; $display("FAIL rw_bypass got=%0h exp=0", bypass_lsu0_o); end
    dmem_rvalid_i = 1; dmem_rdata_i = 32'hDEADBEEF; #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rw_stall_rv got=%0h exp=0", stall_o); end
    tick(); dmem_rvalid_i = 0;
    checks++; if ({wb_valid0_o, wb_valid1_o} !== 2'b00) begin errors++; $display("FAIL rw_rv_ignored got=%0h exp=0", {wb_valid0_o, wb_valid1_o}); end
    valid0_i = 1; rd_we0_i = 1; rd0_i = 3; alu0_i = 32'h77;
    tick(); clear_in(); tick();
    checks++; if ({wb_valid0_o, wb_we0_o, wb_rd0_o} !== {2'b11, 5'd3}) begin errors++; $display("FAIL rw_next_ctl got=%0h exp=63", {wb_valid0_o, wb_we0_o, wb_rd0_o}); end
    checks++; if (wb_data0_o !== 32'h77) begin errors++; $display("FAIL rw_next_data got=%0h exp=77", wb_data0_o); end
  endtask

  task automatic test_load_lbu();
    clear_in();
    valid0_i = 1; ld0_i = 1; f3_0_i = 3'b100; alu0_i = 32'h4001; rd_we0_i = 1; rd0_i = 10;
    tick(); clear_in(); dmem_gnt_i = 1; #1;
    checks++; if ({dmem_req_o, dmem_addr_o} !== {1'b1, 32'h4000}) begin errors++; $display("FAIL lbu_req got=%0h exp=100004000", {dmem_req_o, dmem_addr_o}); end
    tick(); dmem_gnt_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = 32'h0000F000; #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lbu_stall_rv got=%0h exp=0", stall_o); end
    tick(); dmem_rvalid_i = 0;
    checks++; if (wb_data0_o !== 32'h000000F0) begin errors++; $display("FAIL lbu_wb_data got=%0h exp=f0", wb_data0_o); end
    checks++; if ({wb_valid0_o, wb_rd0_o} !== {1'b1, 5'd10}) begin errors++; $display("FAIL lbu_wb_rd got=%0h exp=2a", {wb_valid0_o, wb_rd0_o}); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_sb();
    test_store_sh();
    test_load_lh();
    test_misalign();
    test_reset_wait();
    test_load_lbu();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
